// File: rtl/config_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : config_bus_arbiter
// Purpose  : Shares the colour-manager configuration bus between NUM_REQ
//            requesters. Issues one single-cycle C_Valid transaction at a
//            time, waits for the slave's low-then-high C_Rdy acknowledge,
//            and reports Done (with Err on timeout) to the owning requester.
// Options  : CFG_ARB_ROUND_ROBIN_EN - round-robin selection. When undefined
//            the arbiter uses fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module config_bus_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int C_ADDR_WIDTH = 8,
   parameter int C_DATA_WIDTH = 16,
   parameter int ACK_TIMEOUT  = 8
) (
   input  logic                            Clk,
   input  logic                            Rst,
   input  logic [NUM_REQ-1:0]              Req_Valid,
   input  logic [NUM_REQ*C_ADDR_WIDTH-1:0] Req_Addr,
   input  logic [NUM_REQ*C_DATA_WIDTH-1:0] Req_Data,
   output logic [NUM_REQ-1:0]              Req_Rdy,
   output logic [NUM_REQ-1:0]              Req_Done,
   output logic                            Req_Err,
   output logic [C_ADDR_WIDTH-1:0]         C_Addr,
   output logic [C_DATA_WIDTH-1:0]         C_Data,
   output logic                            C_Valid,
   input  logic                            C_Rdy,
   output logic                            Busy
);

   localparam int CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
   localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(ACK_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t                  state, state_next;
   logic [CNT_WIDTH-1:0]    cnt, cnt_next, cnt_inc;
   logic [NUM_REQ-1:0]      owner, owner_next;   // one-hot owner of the transaction
   logic [NUM_REQ-1:0]      rdy_next, done_next;
   logic                    err_next, valid_next, busy_next;
   logic [C_ADDR_WIDTH-1:0] addr_next;
   logic [C_DATA_WIDTH-1:0] data_next;

   logic                    win_found;
   logic [IDX_WIDTH-1:0]    win_idx;
   logic [NUM_REQ-1:0]      win_oh;
   logic [C_ADDR_WIDTH-1:0] win_addr;
   logic [C_DATA_WIDTH-1:0] win_data;

`ifdef CFG_ARB_ROUND_ROBIN_EN
   logic [IDX_WIDTH-1:0] ptr;
   logic                 above_found, wrap_found;
   logic [IDX_WIDTH-1:0] above_idx, wrap_idx;

   // Round-robin pick: lowest request above the pointer, else wrap to the lowest overall.
   always_comb begin
      above_found = 1'b0;
      wrap_found  = 1'b0;
      above_idx   = '0;
      wrap_idx    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (Req_Valid[i]) begin
            if (i > int'(ptr)) begin
               above_found = 1'b1;
               above_idx   = IDX_WIDTH'(i);
            end else begin
               wrap_found = 1'b1;
               wrap_idx   = IDX_WIDTH'(i);
            end
         end
      end
      win_found = above_found | wrap_found;
      win_idx   = above_found ? above_idx : wrap_idx;
   end

   // Pointer remembers the last winner; reset value gives requester 0 first turn.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ptr <= IDX_WIDTH'(NUM_REQ - 1);
      end else if (state == IDLE && win_found && C_Rdy) begin
         ptr <= win_idx;
      end
   end
`else
   // Fixed priority pick: lowest asserted index wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (Req_Valid[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_WIDTH'(i);
         end
      end
   end
`endif

   // Decode the winner into a one-hot and select its address/data.
   always_comb begin
      win_oh   = '0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_found && (win_idx == IDX_WIDTH'(i))) begin
            win_oh[i] = 1'b1;
            win_addr  = Req_Addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            win_data  = Req_Data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
         end
      end
   end

   // Saturating increment so the counter can never wrap.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and next-output logic. The counter holds the number of cycles
   // already spent in the current wait (including the ISSUE cycle for
   // WAIT_LOW, and the first low cycle for WAIT_HIGH), so the timeout fires
   // on the cycle that would make it ACK_TIMEOUT.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      owner_next = owner;
      addr_next  = C_Addr;
      data_next  = C_Data;
      valid_next = 1'b0;
      rdy_next   = '0;
      done_next  = '0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (win_found && C_Rdy) begin
               owner_next = win_oh;
               addr_next  = win_addr;
               data_next  = win_data;
               cnt_next   = '0;
               valid_next = 1'b1;
               rdy_next   = win_oh;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = cnt_inc;
            state_next = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!C_Rdy) begin
               cnt_next   = CNT_WIDTH'(1);
               state_next = WAIT_HIGH;
            end else if (cnt >= CNT_LAST) begin
               done_next  = owner;
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         WAIT_HIGH: begin
            if (C_Rdy) begin
               done_next  = owner;
               state_next = IDLE;
            end else if (cnt >= CNT_LAST) begin
               done_next  = owner;
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // Registered outputs and datapath; reset clears every pulse immediately.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt      <= '0;
         owner    <= '0;
         C_Valid  <= 1'b0;
         Req_Rdy  <= '0;
         Req_Done <= '0;
         Req_Err  <= 1'b0;
         C_Addr   <= '0;
         C_Data   <= '0;
         Busy     <= 1'b0;
      end else begin
         cnt      <= cnt_next;
         owner    <= owner_next;
         C_Valid  <= valid_next;
         Req_Rdy  <= rdy_next;
         Req_Done <= done_next;
         Req_Err  <= err_next;
         C_Addr   <= addr_next;
         C_Data   <= data_next;
         Busy     <= busy_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_config_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_bus_arbiter
// Purpose  : Self-checking bench for config_bus_arbiter. A transaction-level
//            model predicts the winner and the Done cycle/Err from the slave's
//            C_Rdy pattern. Honours CFG_ARB_ROUND_ROBIN_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_bus_arbiter;

   localparam int NUM_REQ     = 3;
   localparam int AW          = 8;
   localparam int DW          = 16;
   localparam int ACK_TIMEOUT = 8;

   logic                    Clk = 1'b0;
   logic                    Rst = 1'b0;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*AW-1:0]   req_addr;
   logic [NUM_REQ*DW-1:0]   req_data;
   logic                    c_rdy;
   logic [NUM_REQ-1:0]      Req_Rdy, Req_Done;
   logic                    Req_Err, C_Valid, Busy;
   logic [AW-1:0]           C_Addr;
   logic [DW-1:0]           C_Data;

   int checks = 0;
   int passes = 0;
   int m_ptr;
   logic [AW-1:0] m_addr [NUM_REQ];
   logic [DW-1:0] m_data [NUM_REQ];

   config_bus_arbiter #(
      .NUM_REQ(NUM_REQ), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Req_Valid(req_valid), .Req_Addr(req_addr), .Req_Data(req_data),
      .Req_Rdy(Req_Rdy), .Req_Done(Req_Done), .Req_Err(Req_Err), .C_Addr(C_Addr),
      .C_Data(C_Data), .C_Valid(C_Valid), .C_Rdy(c_rdy), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
      m_addr[i] = a;
      m_data[i] = d;
   endtask

   // Arbitration rule: round-robin from pointer+1, or lowest index.
   function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int ptr);
      int w = -1;
`ifdef CFG_ARB_ROUND_ROBIN_EN
      for (int k = NUM_REQ; k >= 1; k--) if (v[(ptr + k) % NUM_REQ]) w = (ptr + k) % NUM_REQ;
`else
      for (int k = NUM_REQ - 1; k >= 0; k--) if (v[k]) w = k;
`endif
      return w;
   endfunction

   // Slave pattern: C_Rdy is low for cycles [j, j+len) counted from ISSUE (cycle 0).
   function automatic void exp_done(input int j, input int len, output int ofs, output logic e);
      if (j >= ACK_TIMEOUT) begin ofs = ACK_TIMEOUT; e = 1'b1; end
      else if (len >= ACK_TIMEOUT) begin ofs = j + ACK_TIMEOUT; e = 1'b1; end
      else begin ofs = j + len + 1; e = 1'b0; end
   endfunction

   // Plays the slave for one transaction and reports what was observed.
   task automatic run_txn(input int j, input int len, input bit drop,
                          output int gnt, output logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [NUM_REQ-1:0] rdy_vec, output int wait_cyc,
                          output int done_ofs, output logic err, output logic [NUM_REQ-1:0] done_vec,
                          output int vpulses, output bit busy_ok, output bit err_clean);
      gnt = -1; addr = '0; data = '0; rdy_vec = '0; wait_cyc = 0; done_ofs = -1;
      err = 1'b0; done_vec = '0; vpulses = 0; busy_ok = 1'b1; err_clean = 1'b1;
      c_rdy = 1'b1;
      while (wait_cyc < 20 && C_Valid !== 1'b1) begin
         step();
         wait_cyc++;
      end
      if (C_Valid === 1'b1) begin
         rdy_vec = Req_Rdy; addr = C_Addr; data = C_Data; vpulses = 1;
         busy_ok = (Busy === 1'b1);
         for (int i = NUM_REQ - 1; i >= 0; i--) if (Req_Rdy[i]) gnt = i;
         if (drop && gnt >= 0) req_valid[gnt] = 1'b0;
         for (int t = 1; t <= 40 && done_ofs < 0; t++) begin
            step();
            c_rdy = (t >= j && t < j + len) ? 1'b0 : 1'b1;
            if (C_Valid === 1'b1) vpulses++;
            if (Req_Done !== '0) begin
               done_ofs = t; err = Req_Err; done_vec = Req_Done;
               if (Busy !== 1'b0) busy_ok = 1'b0;
            end else begin
               if (Req_Err !== 1'b0) err_clean = 1'b0;
               if (Busy !== 1'b1) busy_ok = 1'b0;
            end
         end
      end
   endtask

   int g, wc, dofs, vp, eofs, w;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [NUM_REQ-1:0] rv, dv;
   logic er, eerr;
   bit bok, eok;

   task automatic test_reset();
      req_valid = '0; req_addr = '0; req_data = '0; c_rdy = 1'b1; Rst = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if ({C_Valid, Busy, Req_Err, Req_Rdy, Req_Done, C_Addr, C_Data} !== '0)
         $display("FAIL reset_outputs: got %0h want 0", {C_Valid, Busy, Req_Err, Req_Rdy, Req_Done, C_Addr, C_Data});
      else passes++;
      Rst = 1'b1;
      m_ptr = NUM_REQ - 1;
      step();
   endtask

   task automatic test_single();
      set_req(0, 8'h02, 16'h0005);
      req_valid = 3'b001;
      w = exp_winner(req_valid, m_ptr);
      exp_done(2, 1, eofs, eerr);
      run_txn(2, 1, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = w;
      checks++; if (g !== w) $display("FAIL single_grant: got %0d want %0d", g, w); else passes++;
      checks++; if (a !== 8'h02 || d !== 16'h0005) $display("FAIL single_addr_data: got %0h/%0h want 02/0005", a, d); else passes++;
      checks++; if (rv !== 3'b001) $display("FAIL single_req_rdy: got %b want 001", rv); else passes++;
      checks++; if (dofs !== eofs || eofs !== 4) $display("FAIL single_done_cycle: got %0d want %0d", dofs, eofs); else passes++;
      checks++; if (er !== eerr || dv !== 3'b001) $display("FAIL single_done_err: got %b/%b want %b/001", er, dv, eerr); else passes++;
      checks++; if (vp !== 1) $display("FAIL single_valid_pulses: got %0d want 1", vp); else passes++;
      checks++; if (bok !== 1'b1 || eok !== 1'b1) $display("FAIL single_busy_err_quiet: got %b/%b want 1/1", bok, eok); else passes++;
      repeat (3) step();
      checks++;
      if (C_Addr !== 8'h02 || C_Data !== 16'h0005 || C_Valid !== 1'b0 || Busy !== 1'b0)
         $display("FAIL single_hold: got %0h/%0h v%b b%b want 02/0005 v0 b0", C_Addr, C_Data, C_Valid, Busy);
      else passes++;
   endtask

   task automatic test_timeout();
      set_req(1, 8'h7A, 16'hBEEF);
      req_valid = 3'b010;
      w = exp_winner(req_valid, m_ptr);
      exp_done(99, 0, eofs, eerr);
      run_txn(99, 0, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = w;
      checks++; if (g !== 1 || a !== 8'h7A) $display("FAIL timeout_grant: got %0d/%0h want 1/7a", g, a); else passes++;
      checks++; if (dofs !== eofs) $display("FAIL timeout_cycle: got %0d want %0d", dofs, eofs); else passes++;
      checks++; if (er !== 1'b1 || dv !== 3'b010) $display("FAIL timeout_err: got %b/%b want 1/010", er, dv); else passes++;
   endtask

   task automatic test_stuck();
      int bad;
      set_req(0, 8'h11, 16'h2222);
      req_valid = 3'b001;
      exp_done(1, 20, eofs, eerr);
      run_txn(1, 20, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = 0;
      checks++; if (dofs !== eofs || er !== eerr) $display("FAIL stuck_done: got %0d/%b want %0d/%b", dofs, er, eofs, eerr); else passes++;
      set_req(2, 8'h33, 16'h4444);
      req_valid = 3'b100;
      bad = 0;
      for (int t = dofs + 1; t < 21; t++) begin
         c_rdy = 1'b0;
         step();
         if (C_Valid !== 1'b0 || Busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL stuck_no_grant: got %0d busy cycles want 0", bad); else passes++;
      w = exp_winner(req_valid, m_ptr);
      run_txn(1, 1, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = w;
      checks++; if (g !== w || a !== 8'h33 || wc !== 1) $display("FAIL stuck_recover: got %0d/%0h/%0d want %0d/33/1", g, a, wc, w); else passes++;
      checks++; if (dofs !== 3 || er !== 1'b0) $display("FAIL stuck_recover_done: got %0d/%b want 3/0", dofs, er); else passes++;
   endtask

   task automatic test_contention();
      Rst = 1'b0;
      step();
      Rst = 1'b1;
      m_ptr = NUM_REQ - 1;
      set_req(0, 8'hA0, 16'h00A0);
      set_req(1, 8'hB1, 16'h00B1);
      req_valid = 3'b011;
      for (int n = 0; n < 4; n++) begin
         w = exp_winner(req_valid, m_ptr);
         run_txn(1, 1, 1'b0, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
         m_ptr = w;
         checks++;
         if (g !== w || w < 0 || a !== m_addr[w] || d !== m_data[w] || dofs !== 3)
            $display("FAIL contention_%0d: got %0d/%0h/%0d want %0d/%0h/3", n, g, a, dofs, w, (w >= 0) ? m_addr[w] : 8'h00);
         else passes++;
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      int k, bad;
      set_req(0, 8'h55, 16'h6666);
      req_valid = 3'b001;
      c_rdy = 1'b1;
      k = 0;
      while (k < 20 && C_Valid !== 1'b1) begin step(); k++; end
      checks++; if (C_Valid !== 1'b1) $display("FAIL rstmid_issue: got %b want 1", C_Valid); else passes++;
      req_valid = '0;
      repeat (3) step();
      checks++; if (Busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", Busy); else passes++;
      #2 Rst = 1'b0;
      #1;
      checks++;
      if ({C_Valid, Busy, Req_Err, Req_Rdy, Req_Done, C_Addr, C_Data} !== '0)
         $display("FAIL rstmid_async_clear: got %0h want 0", {C_Valid, Busy, Req_Err, Req_Rdy, Req_Done, C_Addr, C_Data});
      else passes++;
      step();
      Rst = 1'b1;
      m_ptr = NUM_REQ - 1;
      bad = 0;
      repeat (12) begin
         step();
         if (Req_Done !== '0 || C_Valid !== 1'b0 || Busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL rstmid_no_done: got %0d bad cycles want 0", bad); else passes++;
      set_req(1, 8'h77, 16'h8888);
      req_valid = 3'b010;
      w = exp_winner(req_valid, m_ptr);
      run_txn(1, 2, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = w;
      checks++; if (g !== 1 || a !== 8'h77 || dofs !== 4 || er !== 1'b0) $display("FAIL rstmid_fresh: got %0d/%0h/%0d/%b want 1/77/4/0", g, a, dofs, er); else passes++;
   endtask

   task automatic test_back_to_back();
      set_req(0, 8'h01, 16'h0101);
      req_valid = 3'b001;
      run_txn(1, 1, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = 0;
      checks++; if (g !== 0 || dv !== 3'b001 || vp !== 1) $display("FAIL b2b_first: got %0d/%b/%0d want 0/001/1", g, dv, vp); else passes++;
      set_req(1, 8'h02, 16'h0202);
      req_valid[1] = 1'b1;
      exp_done(2, 3, eofs, eerr);
      run_txn(2, 3, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
      m_ptr = 1;
      checks++; if (wc !== 1 || g !== 1 || a !== 8'h02) $display("FAIL b2b_grant: got wait %0d gnt %0d addr %0h want 1/1/02", wc, g, a); else passes++;
      checks++; if (vp !== 1 || dofs !== eofs || er !== eerr) $display("FAIL b2b_done: got %0d/%0d/%b want 1/%0d/%b", vp, dofs, er, eofs, eerr); else passes++;
   endtask

   task automatic test_random();
      int j, len;
      for (int n = 0; n < 24; n++) begin
         req_valid = '0;
         for (int i = 0; i < NUM_REQ; i++) set_req(i, AW'($urandom), DW'($urandom));
         req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         w = exp_winner(req_valid, m_ptr);
         j = $urandom_range(1, 9);
         len = $urandom_range(1, 10);
         exp_done(j, len, eofs, eerr);
         run_txn(j, len, 1'b1, g, a, d, rv, wc, dofs, er, dv, vp, bok, eok);
         checks++;
         if (g !== w || w < 0 || a !== m_addr[w] || d !== m_data[w] || wc !== 1 || rv !== dv)
            $display("FAIL random_%0d_grant: got %0d/%0h/%0h wait %0d want %0d", n, g, a, d, wc, w);
         else passes++;
         checks++;
         if (dofs !== eofs || er !== eerr || vp !== 1 || bok !== 1'b1 || eok !== 1'b1)
            $display("FAIL random_%0d_done: got %0d/%b vp %0d want %0d/%b (j=%0d len=%0d)", n, dofs, er, vp, eofs, eerr, j, len);
         else passes++;
         m_ptr = w;
         req_valid = '0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_timeout();
      test_stuck();
      test_contention();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/config_bus_arbiter.md
Name: config_bus_arbiter

Overview:
- Shares the single configuration bus (C_Addr/C_Data/C_Valid/C_Rdy) that feeds the colour manager between NUM_REQ requesters, for example the UART command decoder and the preset/demo sequencer.
- Issues one single-cycle C_Valid transaction at a time and waits for the slave's acknowledge.
- The slave acknowledges by driving C_Rdy low for at least one cycle and then returning it high.
- Reports completion or timeout back to the requester that owns the transaction.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- C_ADDR_WIDTH, 8, config bus address width.
- C_DATA_WIDTH, 16, config bus data width.
- ACK_TIMEOUT, 8, cycles after C_Valid within which C_Rdy must go low; also the maximum number of cycles C_Rdy may stay low.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-low.
- Req_Valid  in  NUM_REQ  per-requester transaction request.
- Req_Addr  in  NUM_REQ*C_ADDR_WIDTH  flattened addresses; requester i uses bits [i*C_ADDR_WIDTH +: C_ADDR_WIDTH].
- Req_Data  in  NUM_REQ*C_DATA_WIDTH  flattened data, same packing.
- Req_Rdy  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- Req_Done  out  NUM_REQ  one-cycle completion pulse to the owner.
- Req_Err  out  1  qualifies Req_Done: 1 = timeout, 0 = acknowledged.
- C_Addr  out  C_ADDR_WIDTH  config bus address.
- C_Data  out  C_DATA_WIDTH  config bus data.
- C_Valid  out  1  config bus valid.
- C_Rdy  in  1  slave ready; the slave drives it low after accepting.
- Busy  out  1  high while not in IDLE.

Behaviour:
- Reset (Rst=0, asynchronous):
  - All outputs 0, counter 0, state IDLE.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If |Req_Valid and C_Rdy=1 at edge n: pick winner w, latch Req_Addr[w] and Req_Data[w] into C_Addr/C_Data, go to ISSUE.
  - If C_Rdy=0, no grant is made; requests wait.
- ISSUE (cycle n+1):
  - C_Valid=1 and Req_Rdy[w]=1, each for exactly this cycle.
  - Clear the counter, go to WAIT_LOW.
- Requester handshake rules:
  - A requester holds Valid/Addr/Data stable until it sees Req_Rdy.
  - It may drop Valid before a grant with no side effect.
  - The arbiter never samples requester inputs outside IDLE.
- WAIT_LOW:
  - Counter increments each cycle.
  - C_Rdy=0 → go to WAIT_HIGH and clear the counter.
  - Counter reaches ACK_TIMEOUT with C_Rdy still 1 → Req_Done[w]=1 and Req_Err=1 for one cycle, go to IDLE. This covers an unknown address or a slave in debug bypass.
- WAIT_HIGH:
  - C_Rdy=1 → Req_Done[w]=1 and Req_Err=0 for one cycle, go to IDLE.
  - C_Rdy held low for ACK_TIMEOUT cycles → Done with Err=1, go to IDLE.
- Latency and timing:
  - Minimum grant-to-Done latency: ISSUE + 1 low cycle + 1 high detect = Done 3 cycles after ISSUE.
  - A new grant is possible the cycle after Done (back-to-back: one IDLE cycle between transactions).
- C_Addr/C_Data hold their last values after the transaction and change only on a grant.
- Req_Err is 0 whenever no Req_Done bit is set.
- Counter width is clog2(ACK_TIMEOUT+1) and saturates; it never wraps.
- A grant sets the round-robin pointer to w.
- Reset asserted mid-transaction: immediate return to IDLE, all pulses cleared, and no Done is issued for the aborted transaction.

Optional Feature:
- Macro: CFG_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection. The search starts at pointer+1 modulo NUM_REQ; the first asserted Req_Valid wins.
- Undefined: fixed priority, lowest asserted index wins. The pointer register is absent and starvation of higher indices is accepted.

Test Plan:
- Single request:
  - Stimulus: Req_Valid=01, Addr0=0x02, Data0=0x0005; C_Rdy low 1 cycle, 2 cycles after ISSUE.
  - Response: C_Valid for one cycle with C_Addr=0x02, C_Data=0x0005; Req_Rdy[0] coincident with C_Valid; Req_Done[0] with Err=0; Busy falls the same cycle as Done.
- Ack timeout: C_Rdy held 1 permanently, one request from requester 1 → Req_Done[1] and Req_Err=1 exactly ACK_TIMEOUT=8 cycles after ISSUE.
- Stuck slave: C_Rdy driven low after ISSUE and held low 20 cycles → Done with Err=1 after 8 low cycles; no new grant while C_Rdy=0 in IDLE.
- Contention, CFG_ARB_ROUND_ROBIN_EN defined: both requesters continuously valid for 4 transactions → grant order 0,1,0,1. Undefined: order 0,0,0,0.
- Reset mid-WAIT_LOW: Rst pulsed low → all outputs 0 asynchronously, no Req_Done; after release, a fresh request is granted normally.
- Simultaneous end-of-transaction and new request: Req_Valid[1] rises the cycle Done[0] pulses → granted on the next IDLE edge with no lost or duplicated C_Valid.
